mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit of the multicycle datapath. It computes MIPS `mult`/`div` results iteratively, one bit per clock, and holds them in the HI and LO registers. Those registers drive the write-back select's `hi` and `lo` data inputs for `mfhi`/`mflo`. The control unit starts an operation with a one-cycle strobe and stalls on `busy` until `done`.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_cond_neg.sv | 21 ++
 rtl/mult_div_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the sequential multiply/divide unit.
//   mduState_t   - FSM state encoding (IDLE, MULT, DIV, FIX)
//   MDU_ITER     - default iteration count (one result bit per clock)
//   MDU_CNT_W    - iteration counter width for the default configuration
//   mduCntWidth  - counter width for an arbitrary iteration count
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FIX
  } mduState_t;

  localparam int unsigned MDU_ITER  = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_ITER + 1);

  function automatic int unsigned mduCntWidth(input int unsigned iter);
    return $clog2(iter + 1);
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// mdu_cond_neg: combinational conditional two's-complement negate.
// Ports:
//   negate - when 1, result = -value; otherwise result = value
//   value  - W-bit input
//   result - W-bit output
module mdu_cond_neg #(
  parameter int unsigned W = 32
) (
  input  logic         negate,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  always_comb begin
    result = value;
    if (negate) begin
      result = ~value + W'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide unit (MIPS mult/div),
// one result bit per clock, results held in HI/LO.
// Optional feature macro: MDU_UNSIGNED_OPS_EN adds is_unsigned (multu/divu).
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start_mult, start_div - one-cycle start strobes (multiply has priority)
//   in_a, in_b            - rs / rt operands, sampled on the accepting edge
//   is_unsigned           - (MDU_UNSIGNED_OPS_EN only) unsigned operation
//   busy                  - operation in progress
//   done                  - one-cycle pulse after HI/LO update
//   div_zero              - last divide had a zero divisor
//   out_hi, out_lo        - HI (product high / remainder), LO (product low / quotient)
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_ITER
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
`ifdef MDU_UNSIGNED_OPS_EN
  input  logic              is_unsigned,
`endif
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo
);

  localparam int unsigned CNT_W = mduCntWidth(DATA_W);

  mduState_t state;
  mduState_t nextState;

  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   operand;
  logic                opMult;
  logic                resNeg;
  logic                remNeg;
  logic                zeroDiv;
  logic [DATA_W-1:0]   hiReg;
  logic [DATA_W-1:0]   loReg;
  logic                doneReg;
  logic                divZeroReg;

  logic                unsMode;
  logic                aSign;
  logic                bSign;
  logic [DATA_W-1:0]   magA;
  logic [DATA_W-1:0]   magB;
  logic                accept;
  logic                lastIter;
  logic                divByZero;

  logic [DATA_W:0]     addSum;
  logic [2*DATA_W-1:0] multNext;
  logic [DATA_W:0]     remShift;
  logic [DATA_W:0]     remDiff;
  logic                qBit;
  logic [DATA_W-1:0]   remNew;
  logic [2*DATA_W-1:0] divNext;

  logic [2*DATA_W-1:0] prodFixed;
  logic [DATA_W-1:0]   quotFixed;
  logic [DATA_W-1:0]   remFixed;

`ifdef MDU_UNSIGNED_OPS_EN
  assign unsMode = is_unsigned;
`else
  assign unsMode = 1'b0;
`endif

  assign aSign     = in_a[DATA_W-1] & ~unsMode;
  assign bSign     = in_b[DATA_W-1] & ~unsMode;
  assign accept    = (state == IDLE) && (start_mult || start_div);
  assign lastIter  = (cnt == CNT_W'(DATA_W - 1));
  assign divByZero = (in_b == '0);

  // Operand magnitudes
  mdu_cond_neg #(.W(DATA_W)) uNegA (
    .negate (aSign),
    .value  (in_a),
    .result (magA)
  );

  mdu_cond_neg #(.W(DATA_W)) uNegB (
    .negate (bSign),
    .value  (in_b),
    .result (magB)
  );

  // Result sign fixup
  mdu_cond_neg #(.W(2*DATA_W)) uNegProd (
    .negate (resNeg),
    .value  (acc),
    .result (prodFixed)
  );

  mdu_cond_neg #(.W(DATA_W)) uNegQuot (
    .negate (resNeg),
    .value  (acc[DATA_W-1:0]),
    .result (quotFixed)
  );

  mdu_cond_neg #(.W(DATA_W)) uNegRem (
    .negate (remNeg),
    .value  (acc[2*DATA_W-1:DATA_W]),
    .result (remFixed)
  );

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  always_comb begin
    addSum = {1'b0, acc[2*DATA_W-1:DATA_W]};
    if (acc[0]) begin
      addSum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, operand};
    end
    multNext = {addSum, acc[DATA_W-1:1]};
  end

  // Restoring-division step: acc = {partial remainder, dividend/quotient bits}
  always_comb begin
    remShift = acc[2*DATA_W-1:DATA_W-1];
    remDiff  = remShift - {1'b0, operand};
    qBit     = (remShift >= {1'b0, operand});
    remNew   = qBit ? remDiff[DATA_W-1:0] : remShift[DATA_W-1:0];
    divNext  = {remNew, acc[DATA_W-2:0], qBit};
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic; a zero divisor skips straight to FIX
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start_mult) begin
          nextState = MULT;
        end else if (start_div) begin
          nextState = divByZero ? FIX : DIV;
        end
      end
      MULT:    if (lastIter) nextState = FIX;
      DIV:     if (lastIter) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state != IDLE);
    done     = doneReg;
    div_zero = divZeroReg;
    out_hi   = hiReg;
    out_lo   = loReg;
  end

  // Datapath: operand capture, iteration, HI/LO write-back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      acc        <= '0;
      operand    <= '0;
      opMult     <= 1'b0;
      resNeg     <= 1'b0;
      remNeg     <= 1'b0;
      zeroDiv    <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            opMult     <= start_mult;
            resNeg     <= aSign ^ bSign;
            remNeg     <= aSign;
            zeroDiv    <= !start_mult && divByZero;
            cnt        <= '0;
            divZeroReg <= 1'b0;
            if (start_mult) begin
              acc     <= {{DATA_W{1'b0}}, magB};
              operand <= magA;
            end else begin
              acc     <= {{DATA_W{1'b0}}, magA};
              operand <= magB;
            end
          end
        end
        MULT: begin
          acc <= multNext;
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc <= divNext;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          doneReg <= 1'b1;
          if (zeroDiv) begin
            divZeroReg <= 1'b1;
          end else if (opMult) begin
            hiReg <= prodFixed[2*DATA_W-1:DATA_W];
            loReg <= prodFixed[DATA_W-1:0];
          end else begin
            hiReg <= remFixed;
            loReg <= quotFixed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (DATA_W = 32).
// Expected HI/LO/div_zero are queued at issue; a monitor pops on each done.
module tb_mult_div_unit;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } expT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
`ifdef MDU_UNSIGNED_OPS_EN
  logic        is_unsigned = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] out_hi;
  logic [31:0] out_lo;

  expT sb[$];
  int  checks = 0;
  int  failures = 0;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_mult (start_mult),
    .start_div  (start_div),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef MDU_UNSIGNED_OPS_EN
    .is_unsigned(is_unsigned),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .out_hi     (out_hi),
    .out_lo     (out_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectRes(input string name, input logic [31:0] hi, input logic [31:0] lo,
                           input logic dz);
    expT e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    e.dz   = dz;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  // Operand inputs are scrambled afterwards: they must be sampled only at start.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    start_mult = m;
    start_div  = d;
    in_a       = a;
    in_b       = b;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    in_a       = ~a;
    in_b       = ~b;
  endtask

  // Counts edges until done; checks latency and that busy stays high until then.
  task automatic waitDone(input string name, input int expLat);
    int   lat;
    logic gap;
    lat = 0;
    gap = 1'b0;
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) gap = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done after %0d cycles, required %0d", name, lat, expLat);
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(expLat));
      chk({name, "_busy_gap"}, 32'(gap), 32'd0);
      chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 hi=0x%08h lo=0x%08h, required no done", out_hi, out_lo);
      end else begin
        expT e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, out_hi, e.hi);
        chk({e.name, "_lo"}, out_lo, e.lo);
        chk({e.name, "_divzero"}, 32'(div_zero), 32'(e.dz));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_hi", out_hi, 32'h0);
    chk("reset_lo", out_lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_divzero", 32'(div_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 7 * -3 = -21, done exactly one cycle
    expectRes("mul_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    waitDone("mul_7_m3", 33);
    @(negedge clk);
    chk("mul_7_m3_done_width", 32'(done), 32'd0);

    // -7 / 2 = -3 rem -1
    expectRes("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    waitDone("div_m7_2", 33);

    // Back to back: preload HI=0x12, LO=0x34 via 0x692 / 0x20
    expectRes("preload", 32'h12, 32'h34, 1'b0);
    issue(1'b0, 1'b1, 32'h692, 32'h20);
    waitDone("preload", 33);

    // Divide by zero: HI/LO kept, div_zero set, one-edge latency
    expectRes("div_by_zero", 32'h12, 32'h34, 1'b1);
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    waitDone("div_by_zero", 1);

    // Next start clears div_zero; -1 * -1 = 1
    expectRes("mul_m1_m1", 32'h0, 32'h1, 1'b0);
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("divzero_cleared_on_start", 32'(div_zero), 32'd0);
    waitDone("mul_m1_m1", 33);

    // Overflow divide wraps without trap
    expectRes("div_ovf", 32'h0, 32'h8000_0000, 1'b0);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div_ovf", 33);

    // Both strobes: multiply wins (3/4 would give LO=0, HI=3)
    expectRes("mul_priority", 32'h0, 32'hC, 1'b0);
    issue(1'b1, 1'b1, 32'd3, 32'd4);
    waitDone("mul_priority", 33);

    // start_div at edge 5 of a multiply is ignored
    expectRes("start_while_busy", 32'h0, 32'h1E, 1'b0);
    issue(1'b1, 1'b0, 32'd6, 32'd5);
    repeat (4) @(negedge clk);
    start_div = 1'b1;
    in_a      = 32'd100;
    in_b      = 32'd7;
    @(negedge clk);
    start_div = 1'b0;
    waitDone("start_while_busy", 28);
    repeat (3) @(negedge clk);
    chk("start_while_busy_idle", 32'(busy), 32'd0);

    // Reset at edge 10 of a multiply: immediate clear, no done afterwards
    issue(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_hi", out_hi, 32'h0);
    chk("midreset_lo", out_lo, 32'h0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset_stays_idle", 32'(busy), 32'd0);

`ifdef MDU_UNSIGNED_OPS_EN
    is_unsigned = 1'b1;
    expectRes("multu_ff_ff", 32'hFFFF_FFFE, 32'h1, 1'b0);
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("multu_ff_ff", 33);
    expectRes("divu_fff9_2", 32'h1, 32'h7FFF_FFFC, 1'b0);
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    waitDone("divu_fff9_2", 33);
    is_unsigned = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
